// File: rtl/cpu_sequencer.sv
// Multicycle control FSM for the 16-bit RISC datapath: fetch/decode/execute sequencing,
// memory ready handshake with timeout, conditional branches, links, HALT and error states.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int EN_BRANCH   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  input  logic       mem_rdy,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       load_pc,
  output logic       clear_pc,
  output logic       load_ir,
  output logic       load_addr,
  output logic       ram_w_en,
  output logic [1:0] pc_sel,
  output logic       sel_addr,
  output logic       mem_req,
  output logic       halted,
  output logic       err
);

  localparam logic [4:0] S_RST  = 5'd0;
  localparam logic [4:0] S_IF1  = 5'd1;
  localparam logic [4:0] S_IF2  = 5'd2;
  localparam logic [4:0] S_DEC  = 5'd3;
  localparam logic [4:0] S_WIMM = 5'd4;
  localparam logic [4:0] S_GA   = 5'd5;
  localparam logic [4:0] S_GB   = 5'd6;
  localparam logic [4:0] S_EX   = 5'd7;
  localparam logic [4:0] S_WB   = 5'd8;
  localparam logic [4:0] S_ST   = 5'd9;
  localparam logic [4:0] S_AD   = 5'd10;
  localparam logic [4:0] S_LA   = 5'd11;
  localparam logic [4:0] S_MR   = 5'd12;
  localparam logic [4:0] S_WM   = 5'd13;
  localparam logic [4:0] S_GD   = 5'd14;
  localparam logic [4:0] S_PB   = 5'd15;
  localparam logic [4:0] S_MW   = 5'd16;
  localparam logic [4:0] S_BT   = 5'd17;
  localparam logic [4:0] S_BL1  = 5'd18;
  localparam logic [4:0] S_PL   = 5'd19;
  localparam logic [4:0] S_LK   = 5'd20;
  localparam logic [4:0] S_HLT  = 5'd21;
  localparam logic [4:0] S_ERR  = 5'd22;

  localparam logic [4:0] I_MOVI = 5'b110_10;
  localparam logic [4:0] I_MOVR = 5'b110_00;
  localparam logic [4:0] I_ADD  = 5'b101_00;
  localparam logic [4:0] I_CMP  = 5'b101_01;
  localparam logic [4:0] I_AND  = 5'b101_10;
  localparam logic [4:0] I_MVN  = 5'b101_11;
  localparam logic [4:0] I_LDR  = 5'b011_00;
  localparam logic [4:0] I_STR  = 5'b100_00;
  localparam logic [4:0] I_BX   = 5'b010_00;
  localparam logic [4:0] I_BLX  = 5'b010_10;
  localparam logic [4:0] I_BL   = 5'b010_11;
  localparam logic [4:0] I_HALT = 5'b111_00;

  localparam logic BR_EN  = (EN_BRANCH != 0);
  localparam logic TO_EN  = (MEM_TIMEOUT != 0);
  localparam int   CW     = $clog2(MEM_TIMEOUT + 2);
  localparam logic [CW-1:0] TO_LIM = CW'(MEM_TIMEOUT);

  typedef struct packed {
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic       w_en;
    logic       en_A;
    logic       en_B;
    logic       en_C;
    logic       en_status;
    logic       sel_A;
    logic       sel_B;
    logic       load_pc;
    logic       clear_pc;
    logic       load_ir;
    logic       load_addr;
    logic       ram_w_en;
    logic [1:0] pc_sel;
    logic       sel_addr;
    logic       mem_req;
    logic       halted;
    logic       err;
  } ctl_t;

  logic [4:0]    state_q, state_d;
  logic [4:0]    dec_next_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc_s;
  logic          timeout_s;
  logic [4:0]    opc_op_s;
  logic          cond_ok_s;
  logic          taken_s;
  ctl_t          ctl_q;

  // Control word for a state; the instruction only matters for EX, where MOV/MVN zero the A side.
  function automatic ctl_t ctl_of(input logic [4:0] st, input logic [4:0] ir);
    ctl_t c;
    c = '0;
    c.sel_addr = 1'b1;
    case (st)
      S_RST:  c.clear_pc = 1'b1;
      S_IF1:  c.mem_req = 1'b1;
      S_IF2:  begin c.load_ir = 1'b1; c.load_pc = 1'b1; c.pc_sel = 2'b00; end
      S_WIMM: begin c.reg_sel = 2'b10; c.wb_sel = 2'b10; c.w_en = 1'b1; end
      S_GA:   begin c.reg_sel = 2'b10; c.en_A = 1'b1; end
      S_GB:   begin c.reg_sel = 2'b01; c.en_B = 1'b1; end
      S_EX:   begin
        c.en_C  = 1'b1;
        c.sel_A = (ir[4:2] == 3'b110) || (ir == I_MVN);
      end
      S_WB:   begin c.reg_sel = 2'b00; c.wb_sel = 2'b00; c.w_en = 1'b1; end
      S_ST:   c.en_status = 1'b1;
      S_AD:   begin c.sel_B = 1'b1; c.en_C = 1'b1; end
      S_LA:   c.load_addr = 1'b1;
      S_MR:   begin c.sel_addr = 1'b0; c.mem_req = 1'b1; end
      S_WM:   begin c.reg_sel = 2'b00; c.wb_sel = 2'b11; c.w_en = 1'b1; end
      S_GD:   begin c.reg_sel = 2'b00; c.en_B = 1'b1; end
      S_PB:   begin c.sel_A = 1'b1; c.en_C = 1'b1; end
      S_MW:   begin c.sel_addr = 1'b0; c.mem_req = 1'b1; c.ram_w_en = 1'b1; end
      S_BT:   begin c.load_pc = 1'b1; c.pc_sel = 2'b01; end
      S_BL1:  begin
        c.w_en = 1'b1; c.reg_sel = 2'b11; c.wb_sel = 2'b01;
        c.load_pc = 1'b1; c.pc_sel = 2'b01;
      end
      S_PL:   begin c.load_pc = 1'b1; c.pc_sel = 2'b10; end
      S_LK:   begin c.reg_sel = 2'b11; c.wb_sel = 2'b01; c.w_en = 1'b1; end
      S_HLT:  begin c.halted = 1'b1; c.sel_addr = 1'b0; end
      S_ERR:  begin c.halted = 1'b1; c.err = 1'b1; end
      default: begin c.halted = 1'b1; c.err = 1'b1; end
    endcase
    return c;
  endfunction

  assign opc_op_s  = {opcode, op};
  assign cnt_inc_s = cnt_q + CW'(1);
  assign timeout_s = TO_EN && (cnt_inc_s == TO_LIM);

  // Branch condition evaluation from Z/N/V; codes 101..111 are undefined.
  always_comb begin
    cond_ok_s = 1'b1;
    taken_s   = 1'b0;
    case (cond)
      3'b000:  taken_s = 1'b1;
      3'b001:  taken_s = Z;
      3'b010:  taken_s = ~Z;
      3'b011:  taken_s = N ^ V;
      3'b100:  taken_s = (N ^ V) | Z;
      default: cond_ok_s = 1'b0;
    endcase
  end

  // Instruction decode out of DEC.
  always_comb begin
    dec_next_s = S_ERR;
    casez (opc_op_s)
      I_MOVI:                    dec_next_s = S_WIMM;
      I_MOVR, I_MVN:             dec_next_s = S_GB;
      I_ADD, I_AND, I_CMP:       dec_next_s = S_GA;
      I_LDR, I_STR:              dec_next_s = S_GA;
      I_HALT:                    dec_next_s = S_HLT;
      5'b001_??: begin
        if (!BR_EN || !cond_ok_s) begin
          dec_next_s = S_ERR;
        end else if (taken_s) begin
          dec_next_s = S_BT;
        end else begin
          dec_next_s = S_IF1;
        end
      end
      I_BL:                      dec_next_s = BR_EN ? S_BL1 : S_ERR;
      I_BX, I_BLX:               dec_next_s = BR_EN ? S_GD : S_ERR;
      default:                   dec_next_s = S_ERR;
    endcase
  end

  // Next-state and wait-counter logic; the counter is zero outside wait states.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_RST:  state_d = S_IF1;
      S_IF1, S_MR, S_MW: begin
        if (mem_rdy) begin
          if (state_q == S_IF1) begin
            state_d = S_IF2;
          end else if (state_q == S_MR) begin
            state_d = S_WM;
          end else begin
            state_d = S_IF1;
          end
        end else if (timeout_s) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      S_IF2:  state_d = S_DEC;
      S_DEC:  state_d = dec_next_s;
      S_WIMM, S_WB, S_ST, S_WM, S_BT, S_BL1, S_PL: state_d = S_IF1;
      S_GA:   state_d = ((opc_op_s == I_LDR) || (opc_op_s == I_STR)) ? S_AD : S_GB;
      S_GB:   state_d = (opc_op_s == I_CMP) ? S_ST : S_EX;
      S_EX:   state_d = S_WB;
      S_AD:   state_d = S_LA;
      S_LA:   state_d = (opc_op_s == I_LDR) ? S_MR : S_GD;
      S_GD:   state_d = S_PB;
      S_PB: begin
        if (opc_op_s == I_STR) begin
          state_d = S_MW;
        end else if (opc_op_s == I_BLX) begin
          state_d = S_LK;
        end else begin
          state_d = S_PL;
        end
      end
      S_LK:   state_d = S_PL;
      S_HLT:  state_d = S_HLT;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // State, counter and registered control word (decoded from the next state so outputs track state_q).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      ctl_q   <= ctl_of(S_RST, 5'b000_00);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_of(state_d, opc_op_s);
    end
  end

  assign reg_sel   = ctl_q.reg_sel;
  assign wb_sel    = ctl_q.wb_sel;
  assign w_en      = ctl_q.w_en;
  assign en_A      = ctl_q.en_A;
  assign en_B      = ctl_q.en_B;
  assign en_C      = ctl_q.en_C;
  assign en_status = ctl_q.en_status;
  assign sel_A     = ctl_q.sel_A;
  assign sel_B     = ctl_q.sel_B;
  assign load_pc   = ctl_q.load_pc;
  assign clear_pc  = ctl_q.clear_pc;
  assign load_ir   = ctl_q.load_ir;
  assign load_addr = ctl_q.load_addr;
  assign ram_w_en  = ctl_q.ram_w_en;
  assign pc_sel    = ctl_q.pc_sel;
  assign sel_addr  = ctl_q.sel_addr;
  assign mem_req   = ctl_q.mem_req;
  assign halted    = ctl_q.halted;
  assign err       = ctl_q.err;

endmodule
